ufm_cmd_arbiter: RTL and testbench

- Shares the single UFM command port (cmd/ufm_page/GO, BUSY/ERR) between two requesters.
  - Requester 0: event-save write path.
  - Requester 1: BMC read/erase service path.
- Arbitrates round-robin and sequences one command at a time: GO pulse, BUSY rise, BUSY fall.
- Enforces start and completion timeouts.
- Reports per-requester ack/done/error.
- Sits between the requesting engines and the UFM wishbone command wrapper.

---
 rtl/ufm_pkg.sv | 24 ++
 rtl/ufm_rr_arb2.sv | 28 ++
 rtl/ufm_cmd_arbiter.sv | 152 +++++++++++++++
 tb/tb_ufm_cmd_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ufm_pkg.sv
// Shared UFM command-port definitions: command codes, field widths and arbiter state encoding.
package ufm_pkg;

  localparam int CMD_W  = 3;
  localparam int PAGE_W = 11;

  localparam logic [CMD_W-1:0] UFM_CMD_READ  = 3'd1;
  localparam logic [CMD_W-1:0] UFM_CMD_WRITE = 3'd2;
  localparam logic [CMD_W-1:0] UFM_CMD_ERASE = 3'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_ISSUE      = 3'd1;
  localparam state_t ST_WAIT_START = 3'd2;
  localparam state_t ST_WAIT_END   = 3'd3;
  localparam state_t ST_FINISH     = 3'd4;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [PAGE_W-1:0] page;
  } ufm_req_t;

endpackage

// File: rtl/ufm_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester not granted last wins.
// Combinational grant (zero latency); the pointer only advances when the grant is taken.
module ufm_rr_arb2 (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  logic last_q;

  always_comb begin
    gnt_vld = |req;
    gnt_idx = (req == 2'b11) ? ~last_q : req[1];
  end

  // Reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      last_q <= 1'b1;
    end else if (take && gnt_vld) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/ufm_cmd_arbiter.sv
// Shares one UFM command port between two requesters, one command at a time, with start/completion timeouts.
// Latency: ack in the grant cycle, GO one cycle later; requests are held off while busy or while BUSY is high.
module ufm_cmd_arbiter
  import ufm_pkg::*;
#(
  parameter int START_TO = 16,
  parameter int DONE_TO  = 2000000,
  parameter int CNT_W    = 21
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              req0_i,
  input  logic [CMD_W-1:0]  cmd0_i,
  input  logic [PAGE_W-1:0] page0_i,
  output logic              ack0_o,
  output logic              done0_o,
  output logic              err0_o,
  input  logic              req1_i,
  input  logic [CMD_W-1:0]  cmd1_i,
  input  logic [PAGE_W-1:0] page1_i,
  output logic              ack1_o,
  output logic              done1_o,
  output logic              err1_o,
  output logic [CMD_W-1:0]  cmd,
  output logic [PAGE_W-1:0] ufm_page,
  output logic              GO,
  input  logic              BUSY,
  input  logic              ERR,
  output logic              arb_busy_o,
  output logic              owner_o,
  output logic              timeout_o
);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_TO - 1);

  state_t           state, state_nxt;
  ufm_req_t         sel_req, lat_q;
  logic             gnt_vld, gnt_idx, grant;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q, owner_q, timeout_q;
  logic             start_hit, done_hit;

  ufm_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .req      ({req1_i, req0_i}),
    .take     (grant),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx)
  );

  // A stale or external wrapper operation blocks new grants until BUSY drops.
  assign grant     = resetn_i && (state == ST_IDLE) && !BUSY && gnt_vld;
  assign start_hit = (cnt_q == START_LAST);
  assign done_hit  = (cnt_q == DONE_LAST);

  always_comb begin
    if (gnt_idx) begin
      sel_req.cmd  = cmd1_i;
      sel_req.page = page1_i;
    end else begin
      sel_req.cmd  = cmd0_i;
      sel_req.page = page0_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (grant) state_nxt = ST_ISSUE;
      ST_ISSUE:      state_nxt = ST_WAIT_START;
      ST_WAIT_START: begin
        if (BUSY)           state_nxt = ST_WAIT_END;
        else if (start_hit) state_nxt = ST_FINISH;
      end
      ST_WAIT_END:   if (!BUSY || done_hit) state_nxt = ST_FINISH;
      ST_FINISH:     state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ack0_o     = grant && !gnt_idx;
    ack1_o     = grant && gnt_idx;
    GO         = (state == ST_ISSUE);
    done0_o    = (state == ST_FINISH) && !owner_q;
    done1_o    = (state == ST_FINISH) && owner_q;
    err0_o     = done0_o && err_q;
    err1_o     = done1_o && err_q;
    arb_busy_o = (state != ST_IDLE);
  end

  assign cmd       = lat_q.cmd;
  assign ufm_page  = lat_q.page;
  assign owner_o   = owner_q;
  assign timeout_o = timeout_q;

  // BUSY falling is tested before the completion limit so it wins a same-cycle tie.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      lat_q     <= '0;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            lat_q   <= sel_req;
            owner_q <= gnt_idx;
            err_q   <= 1'b0;
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT_START: begin
          if (BUSY) begin
            cnt_q <= '0;
            err_q <= 1'b0;
          end else if (start_hit) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_END: begin
          if (!BUSY) begin
            err_q <= err_q | ERR;
          end else if (done_hit) begin
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            err_q <= err_q | ERR;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ufm_cmd_arbiter.sv
// Directed and randomized checks of ufm_cmd_arbiter against an event-schedule reference model.
module tb_ufm_cmd_arbiter;
  import ufm_pkg::*;

  localparam int START_TO = 16;
  localparam int DONE_TO  = 100;

  logic              clk_i    = 1'b0;
  logic              resetn_i = 1'b0;
  logic              req0_i = 1'b0, req1_i = 1'b0;
  logic [CMD_W-1:0]  cmd0_i = '0, cmd1_i = '0;
  logic [PAGE_W-1:0] page0_i = '0, page1_i = '0;
  logic              BUSY = 1'b0, ERR = 1'b0;
  logic              ack0_o, done0_o, err0_o, ack1_o, done1_o, err1_o;
  logic [CMD_W-1:0]  cmd;
  logic [PAGE_W-1:0] ufm_page;
  logic              GO, arb_busy_o, owner_o, timeout_o;

  ufm_cmd_arbiter #(.START_TO(START_TO), .DONE_TO(DONE_TO), .CNT_W(21)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .req0_i(req0_i), .cmd0_i(cmd0_i), .page0_i(page0_i),
    .ack0_o(ack0_o), .done0_o(done0_o), .err0_o(err0_o),
    .req1_i(req1_i), .cmd1_i(cmd1_i), .page1_i(page1_i),
    .ack1_o(ack1_o), .done1_o(done1_o), .err1_o(err1_o),
    .cmd(cmd), .ufm_page(ufm_page), .GO(GO), .BUSY(BUSY), .ERR(ERR),
    .arb_busy_o(arb_busy_o), .owner_o(owner_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0, checks = 0;
  int t = 0, n, g0;

  // Reference model: each command is a set of expected event cycles.
  bit                m_act = 0, m_own = 0, m_err = 0, m_to = 0, m_last = 1;
  int                m_ack = 0, m_go = 0, m_done = 0, grants = 0;
  bit                e_own = 0, e_to = 0;
  logic [CMD_W-1:0]  e_cmd = '0, p_cmd = '0;
  logic [PAGE_W-1:0] e_page = '0, p_page = '0;
  // Wrapper behaviour for the next command: BUSY rises d cycles after GO, stays l cycles, ERR at offset eoff (0: none).
  int                b_lo = -1, b_hi = -2, err_at = -1;
  int                nx_d = 3, nx_l = 5, nx_eoff = 0;
  bit                rnd_wrap = 0, rnd_req = 0, drop_on_ack = 1, logging = 0;
  bit                ackd_v = 0, ackd_i = 0;
  int                ack_log[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_grant(bit idx);
    if (rnd_wrap) begin
      nx_d    = $urandom_range(18, 1);
      nx_l    = ($urandom_range(4, 0) == 0) ? $urandom_range(102, 98) : $urandom_range(12, 1);
      nx_eoff = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(nx_l, 1);
    end
    m_act = 1; m_own = idx; m_last = idx; m_ack = t; m_go = t + 1;
    p_cmd  = idx ? cmd1_i : cmd0_i;
    p_page = idx ? page1_i : page0_i;
    b_lo   = m_go + nx_d;
    b_hi   = b_lo + nx_l - 1;
    err_at = (nx_eoff > 0) ? b_lo + nx_eoff : -1;
    if (nx_d > START_TO) begin
      m_done = m_go + START_TO + 1; m_err = 1; m_to = 1;
    end else if (nx_l > DONE_TO) begin
      m_done = b_lo + 1 + DONE_TO; m_err = 1; m_to = 1;
    end else begin
      m_done = b_lo + nx_l + 1; m_err = (nx_eoff > 0); m_to = 0;
    end
    grants++;
  endtask

  task automatic cycle();
    bit idx;
    if (ackd_v) begin
      ackd_v = 0;
      if (drop_on_ack || (rnd_req && $urandom_range(1, 0) == 0)) begin
        if (ackd_i) req1_i = 1'b0; else req0_i = 1'b0;
      end
      if (rnd_req) begin
        if (ackd_i) begin cmd1_i = 3'($urandom); page1_i = 11'($urandom); end
        else        begin cmd0_i = 3'($urandom); page0_i = 11'($urandom); end
      end
    end
    if (rnd_req) begin
      if (!req0_i && $urandom_range(3, 0) == 0) begin req0_i = 1'b1; cmd0_i = 3'($urandom); page0_i = 11'($urandom); end
      if (!req1_i && $urandom_range(3, 0) == 0) begin req1_i = 1'b1; cmd1_i = 3'($urandom); page1_i = 11'($urandom); end
    end
    BUSY = (t >= b_lo) && (t <= b_hi);
    ERR  = (t == err_at);
    if (resetn_i) begin
      if (m_act && t == m_ack + 1) begin e_own = m_own; e_cmd = p_cmd; e_page = p_page; end
      if (m_act && t == m_done && m_to) e_to = 1;
      if (m_act && t > m_done) m_act = 0;
      if (!m_act && !BUSY && (req0_i || req1_i)) begin
        idx = (req0_i && req1_i) ? !m_last : req1_i;
        model_grant(idx);
        ackd_v = 1; ackd_i = idx;
      end
    end
    #1;
    if (resetn_i) begin
      chk("ack0", ack0_o, m_act && t == m_ack && !m_own);
      chk("ack1", ack1_o, m_act && t == m_ack && m_own);
      chk("go", GO, m_act && t == m_go);
      chk("done0", done0_o, m_act && t == m_done && !m_own);
      chk("done1", done1_o, m_act && t == m_done && m_own);
      chk("err0", err0_o, m_act && t == m_done && !m_own && m_err);
      chk("err1", err1_o, m_act && t == m_done && m_own && m_err);
      chk("arb_busy", arb_busy_o, m_act && t > m_ack);
      chk("owner", owner_o, e_own);
      chk("cmd", cmd, e_cmd);
      chk("ufm_page", ufm_page, e_page);
      chk("timeout", timeout_o, e_to);
      if (logging && ack0_o) ack_log.push_back(0);
      if (logging && ack1_o) ack_log.push_back(1);
    end else begin
      m_act = 0; m_last = 1; e_own = 0; e_cmd = '0; e_page = '0; e_to = 0;
    end
    @(posedge clk_i); #1;
    t++;
  endtask

  task automatic drain();
    int k = 0;
    cycle();
    while ((req0_i || req1_i || m_act) && k < 1000) begin cycle(); k++; end
    if (k >= 1000) begin
      checks++; errors++;
      $error("FAIL drain_bound t=%0d observed=%0d expected<1000", t, k);
    end
    cycle();
  endtask

  task automatic one(bit idx, int d, int l, int eoff, logic [CMD_W-1:0] c, logic [PAGE_W-1:0] p);
    nx_d = d; nx_l = l; nx_eoff = eoff; drop_on_ack = 1;
    if (idx) begin req1_i = 1'b1; cmd1_i = c; page1_i = p; end
    else     begin req0_i = 1'b1; cmd0_i = c; page0_i = p; end
    drain();
  endtask

  initial begin
    @(posedge clk_i); #1;
    resetn_i = 1'b0;
    repeat (3) cycle();
    resetn_i = 1'b1;
    cycle();

    // Single write on port 0, then an erase on port 1 with an ERR pulse mid-BUSY.
    one(0, 3, 10, 0, 3'd2, 11'h005);
    one(1, 2, 8, 3, UFM_CMD_ERASE, 11'h123);

    // Continuous dual requests for four commands: grants alternate starting at 0.
    drop_on_ack = 0; nx_d = 2; nx_l = 4; nx_eoff = 0;
    ack_log.delete(); logging = 1;
    req0_i = 1'b1; cmd0_i = UFM_CMD_WRITE; page0_i = 11'h010;
    req1_i = 1'b1; cmd1_i = UFM_CMD_READ;  page1_i = 11'h020;
    g0 = grants; n = 0;
    while (grants < g0 + 4 && n < 1000) begin cycle(); n++; end
    req0_i = 1'b0; req1_i = 1'b0;
    drain(); logging = 0;
    chk("rr_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("rr_order", (ack_log.size() > i) ? ack_log[i] : 99, i % 2);

    // Start timeout (BUSY never rises), then the start window boundary both ways.
    one(0, 20, 0, 0, UFM_CMD_WRITE, 11'h044);
    one(1, 16, 4, 0, UFM_CMD_READ, 11'h045);
    one(0, 17, 0, 0, UFM_CMD_READ, 11'h046);

    // Completion timeout with BUSY stuck; a port-1 request must wait for BUSY to drop.
    nx_d = 2; nx_l = 150; nx_eoff = 0; drop_on_ack = 1;
    req0_i = 1'b1; cmd0_i = UFM_CMD_WRITE; page0_i = 11'h0c8;
    g0 = grants; n = 0;
    while (grants == g0 && n < 50) begin cycle(); n++; end
    nx_d = 3; nx_l = 5; nx_eoff = 0;
    req1_i = 1'b1; cmd1_i = UFM_CMD_READ; page1_i = 11'h7ff;
    drain();

    // Completion boundary: BUSY falling on the last allowed cycle wins over the timeout.
    one(1, 2, 100, 0, UFM_CMD_READ, 11'h100);
    one(0, 2, 101, 0, UFM_CMD_WRITE, 11'h101);

    // Reset during WAIT_END: no done, outputs cleared, port 0 wins the next tie.
    nx_d = 2; nx_l = 40; nx_eoff = 0; drop_on_ack = 1;
    req0_i = 1'b1; cmd0_i = UFM_CMD_WRITE; page0_i = 11'h3a5;
    n = 0;
    while (!(m_act && t >= m_go + 8) && n < 100) begin cycle(); n++; end
    resetn_i = 1'b0;
    cycle();
    resetn_i = 1'b1;
    nx_d = 2; nx_l = 3; nx_eoff = 0;
    req0_i = 1'b1; cmd0_i = UFM_CMD_READ;  page0_i = 11'h011;
    req1_i = 1'b1; cmd1_i = UFM_CMD_ERASE; page1_i = 11'h022;
    ack_log.delete(); logging = 1;
    drain(); logging = 0;
    chk("rst_first_grant", (ack_log.size() > 0) ? ack_log[0] : 99, 0);
    chk("rst_grant_count", ack_log.size(), 2);

    // Randomized traffic with random wrapper timing, ERR pulses and occasional timeouts.
    rnd_wrap = 1; rnd_req = 1; drop_on_ack = 0;
    repeat (2000) cycle();
    rnd_req = 0; req0_i = 1'b0; req1_i = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
